blood_tally: RTL
================

// Module: blood_tally
// PURPOSE
//  Downstream consumer of the blood-type classifier. Takes each classified sample (3-bit
//  blood_type code plus 1-bit blood_output verdict) over a valid/ready handshake.
//  Keeps per-type saturating counts of accepted (verdict=1) and rejected (verdict=0) samples.
//  On request, streams a report of all 8 types in order to a display/host stage.
// PARAMETERS
//  CNT_W   8   width of each of the 16 counters; saturates at 2**CNT_W-1
// PORTS
//  clk            in   1      single clock, rising edge
//  rst            in   1      synchronous, active-high reset
//  in_valid       in   1      classified sample present
//  in_ready       out  1      block can take a sample this cycle
//  blood_type     in   3      sample type code, 3'b000..3'b111
//  blood_output   in   1      classifier verdict: 1=accept, 0=reject
//  start_report   in   1      single-cycle pulse: begin report
//  busy           out  1      high while a report is in progress
//  rd_valid       out  1      report beat present
//  rd_ready       in   1      consumer takes the report beat
//  rd_type        out  3      type code of the current beat
//  rd_accept_cnt  out  CNT_W  accept count for rd_type
//  rd_reject_cnt  out  CNT_W  reject count for rd_type
// BEHAVIOUR
//  Reset (clk edge with rst=1): all counters=0, state=COUNT, in_ready=1, busy=0,
//   rd_valid=0, rd_type=0, rd_accept_cnt=0, rd_reject_cnt=0. Overrides every other input.
//   If asserted during REPORT, the report is abandoned with no further beats.
//  FSM states: COUNT, REPORT.
//   COUNT: in_ready=1. When in_valid=1, the selected counter increments at that edge.
//     blood_output picks accept_cnt[blood_type] or reject_cnt[blood_type].
//     The new value is visible one cycle later.
//     A counter at 2**CNT_W-1 holds its value (saturates, never wraps).
//     start_report=1 -> REPORT at the next edge. Any sample taken in the same cycle IS counted
//     and IS included in the report.
//   REPORT: in_ready=0, busy=1. in_valid is ignored and samples are not buffered.
//     start_report is ignored.
//     The first beat is type 0. rd_valid rises the cycle after entry (registered outputs).
//     rd_type/counts stay stable while rd_valid=1 and rd_ready=0.
//     Beat accepted (rd_valid & rd_ready) -> the next cycle presents type+1 with no bubble.
//     Accepting type 7 -> rd_valid=0 and busy=0 at the next edge, back to COUNT.
//     in_ready=1 again in that same cycle.
//     rd_ready held high -> 8 beats on 8 consecutive cycles.
//  Reported counts are those present when REPORT was entered. No counter changes during REPORT.
//  busy and in_ready are complements at all times.
// CONFIGURATION
//  BLOOD_TALLY_CLEAR_ON_READ_EN defined:
//   - Both counters of a type are zeroed on the edge where its report beat is accepted.
//   - After a full report, all counters are 0.
//   - Abandoning via rst also zeroes them.
//  Not defined: the report is non-destructive. Counters only clear on rst.
// TESTING
//  1 rst=1 one cycle -> in_ready=1, busy=0, rd_valid=0, all counts 0 (check via report: 8 beats of 0/0).
//  2 feed (type,verdict)=(3'b010,1)x3,(3'b010,0)x1,(3'b111,1)x2, then start_report with rd_ready=1
//    -> beats t0..t7. t2=3/1, t7=2/0, others 0/0. rd_valid high on 8 consecutive cycles.
//  3 CNT_W=2: feed (3'b000,1) x5 -> report t0 accept=3 (saturated), reject=0.
//  4 rd_ready low 4 cycles during beat t3 -> rd_type=3 and counts held stable.
//    in_valid=1 during REPORT -> in_ready=0 and the counts are unchanged in a second report.
//  5 start_report and in_valid (3'b101,0) in the same cycle -> t5 reject=1 in this report.
//  6 rst during beat t4 -> rd_valid=0 next cycle, COUNT, counters 0. With
//    BLOOD_TALLY_CLEAR_ON_READ_EN, a second report after test 2 gives all 0/0;
//    without it, the values are identical to test 2.

Source files
------------

// File: rtl/blood_tally_if.sv
`default_nettype none
// ============================================================================
// Module      : blood_tally_if
// Description : Bundle of the sample handshake, the report request and the
//               report stream used by blood_tally.
//               slave  - view taken by blood_tally
//               master - view taken by the classifier / host side
//               Sample path : in_valid, in_ready, blood_type, blood_output
//               Control     : start_report, busy
//               Report path : rd_valid, rd_ready, rd_type,
//                             rd_accept_cnt, rd_reject_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface blood_tally_if #(
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       blood_type;
    logic             blood_output;
    logic             start_report;
    logic             busy;
    logic             rd_valid;
    logic             rd_ready;
    logic [2:0]       rd_type;
    logic [CNT_W-1:0] rd_accept_cnt;
    logic [CNT_W-1:0] rd_reject_cnt;

    modport slave (
        input  in_valid, blood_type, blood_output, start_report, rd_ready,
        output in_ready, busy, rd_valid, rd_type, rd_accept_cnt, rd_reject_cnt
    );

    modport master (
        output in_valid, blood_type, blood_output, start_report, rd_ready,
        input  in_ready, busy, rd_valid, rd_type, rd_accept_cnt, rd_reject_cnt
    );
endinterface
`default_nettype wire

// File: rtl/blood_tally.sv
`default_nettype none
// ============================================================================
// Module      : blood_tally
// Description : Per-blood-type saturating tally of classifier verdicts.
//               Each accepted sample bumps accept_cnt[type] (verdict=1) or
//               reject_cnt[type] (verdict=0). A start_report pulse freezes
//               the counters and streams 8 beats (type 0..7) with both counts.
// Ports       : clk   - rising-edge clock
//               rst   - synchronous active-high reset
//               tally - blood_tally_if.slave (sample, control, report)
// Parameters  : CNT_W - width of each counter, saturates at 2**CNT_W-1
// Options     : BLOOD_TALLY_CLEAR_ON_READ_EN - when defined, the two counters
//               of a type are zeroed on the edge its report beat is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module blood_tally #(
    parameter int CNT_W = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    blood_tally_if.slave  tally
);

    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       C_LAST_TYPE = 3'd7;

    typedef enum logic [0:0] {
        ST_COUNT  = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_in_ready;
    logic             w_busy;

    logic [CNT_W-1:0] r_acc_cnt [8];
    logic [CNT_W-1:0] r_rej_cnt [8];

    logic             r_rd_valid;
    logic [2:0]       r_rd_type;
    logic [CNT_W-1:0] r_rd_acc;
    logic [CNT_W-1:0] r_rd_rej;

    logic             w_take;
    logic             w_beat_acc;
    logic             w_last_beat;
    logic [2:0]       w_nxt_type;

    // Samples are only taken while counting; in REPORT they are dropped,
    // which is what keeps the reported snapshot consistent.
    assign w_take      = tally.in_valid && (r_state == ST_COUNT);
    assign w_beat_acc  = r_rd_valid && tally.rd_ready;
    assign w_last_beat = w_beat_acc && (r_rd_type == C_LAST_TYPE);
    assign w_nxt_type  = r_rd_type + 3'd1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_COUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_COUNT: begin
                w_in_ready = 1'b1;
                if (tally.start_report) begin
                    w_state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                w_busy = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = ST_COUNT;
                end
            end
            default: begin
                w_state_nxt = ST_COUNT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter bank. Counting (COUNT only) and clear-on-read (REPORT only)
    // can never hit in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_acc_cnt[i] <= '0;
                r_rej_cnt[i] <= '0;
            end
        end else begin
            if (w_take) begin
                if (tally.blood_output) begin
                    if (r_acc_cnt[tally.blood_type] != C_CNT_MAX) begin
                        r_acc_cnt[tally.blood_type] <= r_acc_cnt[tally.blood_type] + C_CNT_ONE;
                    end
                end else begin
                    if (r_rej_cnt[tally.blood_type] != C_CNT_MAX) begin
                        r_rej_cnt[tally.blood_type] <= r_rej_cnt[tally.blood_type] + C_CNT_ONE;
                    end
                end
            end
`ifdef BLOOD_TALLY_CLEAR_ON_READ_EN
            if (w_beat_acc) begin
                r_acc_cnt[r_rd_type] <= '0;
                r_rej_cnt[r_rd_type] <= '0;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Report stream. The first REPORT cycle has rd_valid low and loads
    // beat 0, so a sample counted on the entry edge is already visible.
    // Later beats load type+1 on the accepting edge (no bubble).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_type  <= 3'd0;
            r_rd_acc   <= '0;
            r_rd_rej   <= '0;
        end else if (r_state == ST_REPORT) begin
            if (!r_rd_valid) begin
                r_rd_valid <= 1'b1;
                r_rd_type  <= 3'd0;
                r_rd_acc   <= r_acc_cnt[0];
                r_rd_rej   <= r_rej_cnt[0];
            end else if (w_beat_acc) begin
                if (r_rd_type == C_LAST_TYPE) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_type <= w_nxt_type;
                    r_rd_acc  <= r_acc_cnt[w_nxt_type];
                    r_rd_rej  <= r_rej_cnt[w_nxt_type];
                end
            end
        end
    end

    assign tally.in_ready      = w_in_ready;
    assign tally.busy          = w_busy;
    assign tally.rd_valid      = r_rd_valid;
    assign tally.rd_type       = r_rd_type;
    assign tally.rd_accept_cnt = r_rd_acc;
    assign tally.rd_reject_cnt = r_rd_rej;

endmodule
`default_nettype wire
